// File: rtl/reg_bus_arbiter_if.sv
// Request/response bundle between the register-bus masters and the arbiter.
// Each per-master field is packed, master i occupying slice i of the vector.
interface reg_bus_arbiter_if #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = 14,
  parameter int DATA_W      = 16
);
  logic [NUM_MASTERS-1:0]        req_valid;
  logic [NUM_MASTERS-1:0]        req_ready;
  logic [NUM_MASTERS-1:0]        req_we;
  logic [NUM_MASTERS-1:0]        req_lock;
  logic [NUM_MASTERS*ADDR_W-1:0] req_addr;
  logic [NUM_MASTERS*DATA_W-1:0] req_wdata;
  logic [NUM_MASTERS-1:0]        rsp_valid;
  logic [DATA_W-1:0]             rsp_rdata;

  modport master (
    output req_valid, req_we, req_lock, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_lock, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/reg_bus_arbiter.sv
// Arbitrates several register-bus masters (fixed priority or round-robin, with
// lock) onto a single register bus and returns one completion pulse per request.
module reg_bus_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = 14,
  parameter int DATA_W      = 16,
  parameter int RD_LAT      = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arb_mode,
  reg_bus_arbiter_if.slave  req_bus,
  output logic              wr_en,
  output logic              rd_en,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] write_data,
  input  logic [DATA_W-1:0] read_data,
  output logic              busy,
  output logic [2:0]        grant_id
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD} state_t;

  state_t state, state_nxt;
  logic   accept;

  logic                   we_q;
  logic                   lock_q;
  logic [2:0]             rr_ptr;
  logic [1:0]             cnt;
  logic [NUM_MASTERS-1:0] rsp_valid_q;
  logic [DATA_W-1:0]      rsp_rdata_q;

  logic                   any_valid;
  logic                   owner_valid;
  logic [NUM_MASTERS-1:0] grant_hot;
  logic [NUM_MASTERS-1:0] rot_valid;
  logic [NUM_MASTERS-1:0] win_hot;
  logic [2:0]             fix_win;
  logic [2:0]             rr_off;
  logic [2:0]             winner;
  logic [2:0]             rr_next;
  logic [3:0]             rr_sum;
  logic [3:0]             win_inc;
  logic                   sel_we;
  logic                   sel_lock;
  logic [ADDR_W-1:0]      sel_addr;
  logic [DATA_W-1:0]      sel_wdata;

  always_comb begin
    // NOTE: every signal gets a default first so no path through this block leaves one unassigned (no latch).
    any_valid = |req_bus.req_valid;
    grant_hot = '0;
    fix_win   = '0;
    rr_off    = '0;
    win_hot   = '0;
    sel_we    = 1'b0;
    sel_lock  = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;

    for (int i = 0; i < NUM_MASTERS; i++) begin
      grant_hot[i] = (grant_id == 3'(i));
    end
    owner_valid = |(grant_hot & req_bus.req_valid);

    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      if (req_bus.req_valid[i]) fix_win = 3'(i);
    end

    // Rotate so bit 0 is the master at rr_ptr; the first set bit is the offset.
    rot_valid = NUM_MASTERS'({req_bus.req_valid, req_bus.req_valid} >> rr_ptr);
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      if (rot_valid[i]) rr_off = 3'(i);
    end
    rr_sum = {1'b0, rr_ptr} + {1'b0, rr_off};

    if (lock_q && owner_valid) begin
      winner = grant_id;
    end else if (arb_mode) begin
      winner = (rr_sum >= 4'(NUM_MASTERS)) ? 3'(rr_sum - 4'(NUM_MASTERS)) : rr_sum[2:0];
    end else begin
      winner = fix_win;
    end

    win_inc = {1'b0, winner} + 4'd1;
    rr_next = (win_inc == 4'(NUM_MASTERS)) ? 3'd0 : win_inc[2:0];

    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (winner == 3'(i)) begin
        win_hot[i] = 1'b1;
        sel_we     = req_bus.req_we[i];
        sel_lock   = req_bus.req_lock[i];
        sel_addr   = req_bus.req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata  = req_bus.req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    unique case (state)
      IDLE: begin
        if (any_valid) begin
          accept    = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE:   state_nxt = we_q ? IDLE : WAIT_RD;
      WAIT_RD: if (cnt == 2'd0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    // NOTE: reset is only sampled at the clock edge, so combinational outputs are gated by rst to read 0 throughout a reset cycle.
    wr_en             = rst && (state == ISSUE) && we_q;
    rd_en             = rst && (state == ISSUE) && !we_q;
    busy              = rst && (state != IDLE);
    req_bus.req_ready = (rst && accept) ? win_hot : '0;
  end

  assign req_bus.rsp_valid = rsp_valid_q & {NUM_MASTERS{rst}};
  assign req_bus.rsp_rdata = rsp_rdata_q;

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values and updates together.
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      we_q        <= 1'b0;
      lock_q      <= 1'b0;
      rr_ptr      <= '0;
      cnt         <= '0;
      grant_id    <= '0;
      addr        <= '0;
      write_data  <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= '0;

      if (accept) begin
        we_q       <= sel_we;
        lock_q     <= sel_lock;
        addr       <= sel_addr;
        write_data <= sel_wdata;
        grant_id   <= winner;
        if (arb_mode) rr_ptr <= rr_next;
      end else if (state == IDLE && lock_q && !owner_valid) begin
        lock_q <= 1'b0;
      end

      if (state == ISSUE) begin
        if (we_q) begin
          rsp_valid_q <= grant_hot;
          rsp_rdata_q <= '0;
        end else begin
          cnt <= 2'(RD_LAT - 1);
        end
      end

      if (state == WAIT_RD) begin
        if (cnt == 2'd0) begin
          rsp_valid_q <= grant_hot;
          rsp_rdata_q <= read_data;
        end else begin
          cnt <= cnt - 2'd1;
        end
      end
    end
  end
endmodule

// File: doc/reg_bus_arbiter.md
REG_BUS_ARBITER -- requirements
Module: reg_bus_arbiter

Interface
REQ-001 Parameter NUM_MASTERS, default 2: number of requesting masters (range 2..8); master 0 is the SPI register interface and master 1 is the program driver.
REQ-002 Parameter ADDR_W, default 14: register address width.
REQ-003 Parameter DATA_W, default 16: register data width.
REQ-004 Parameter RD_LAT, default 1: register-file read latency in cycles (range 1..4).
REQ-005 clk  in  1  single clock; all logic on its rising edge.
REQ-006 rst  in  1  synchronous, active-low reset.
REQ-007 arb_mode  in  1  0 = fixed priority (lowest index wins), 1 = round-robin.
REQ-008 req_valid  in  NUM_MASTERS  per-master request valid.
REQ-009 req_ready  out  NUM_MASTERS  per-master request accept; one-hot or zero.
REQ-010 req_we  in  NUM_MASTERS  per-master 1 = write, 0 = read.
REQ-011 req_lock  in  NUM_MASTERS  per-master request to keep the grant after this transaction.
REQ-012 req_addr  in  NUM_MASTERS*ADDR_W  per-master address; master i occupies slice [i*ADDR_W +: ADDR_W].
REQ-013 req_wdata  in  NUM_MASTERS*DATA_W  per-master write data, sliced the same way.
REQ-014 rsp_valid  out  NUM_MASTERS  one-cycle completion pulse to the owning master.
REQ-015 rsp_rdata  out  DATA_W  read data, valid with rsp_valid; 0 for writes.
REQ-016 wr_en, rd_en  out  1 each  register-bus strobes, each high for one cycle.
REQ-017 addr  out  ADDR_W  register-bus address; write_data  out  DATA_W  register-bus write data.
REQ-018 read_data  in  DATA_W  register-bus read data, valid RD_LAT cycles after rd_en.
REQ-019 busy  out  1  high in any state other than IDLE.
REQ-020 grant_id  out  3  index of the current or last-granted master.

Function
REQ-021 The FSM SHALL have three states: IDLE, ISSUE and WAIT_RD.
REQ-022 IDLE behaviour:
- If any req_valid is high, req_ready SHALL assert combinationally for the winner only.
- The winner's we, addr, wdata and lock SHALL be captured, grant_id SHALL update, and the FSM SHALL go to ISSUE.
REQ-023 In fixed-priority mode, the winner SHALL be the lowest-index valid master.
REQ-024 In round-robin mode:
- The search SHALL start at rr_ptr; after each grant, rr_ptr SHALL become (winner+1) mod NUM_MASTERS.
- rr_ptr SHALL update only in round-robin mode.
REQ-025 Lock override: if the previously granted master had lock captured and has req_valid high, it SHALL win regardless of mode; if its req_valid is low in IDLE, the lock SHALL be released.
REQ-026 In ISSUE, the block SHALL drive addr and write_data from the captured request for exactly one cycle, with wr_en = we and rd_en = !we.
REQ-027 After a write in ISSUE:
- rsp_valid[grant_id] SHALL pulse in the following cycle, with rsp_rdata = 0.
- The FSM SHALL return to IDLE.
REQ-028 After a read in ISSUE, the FSM SHALL go to WAIT_RD with a down-counter loaded to RD_LAT-1.
REQ-029 In WAIT_RD, when the counter reaches 0:
- read_data SHALL be sampled into rsp_rdata.
- rsp_valid[grant_id] SHALL pulse in the next cycle.
- The FSM SHALL return to IDLE.
REQ-030 Latency from the accept cycle to rsp_valid SHALL be 2 cycles for a write and 2+RD_LAT cycles for a read; no new request SHALL be accepted while busy.
REQ-031 A master SHALL hold req_valid and its payload stable until req_ready; the block SHALL not require req_valid to stay high after acceptance.
REQ-032 Outside the cycles defined above, wr_en, rd_en and rsp_valid SHALL be 0, and addr and write_data SHALL hold their last values.
REQ-033 A change of arb_mode SHALL take effect at the next IDLE arbitration and SHALL not disturb a transaction in flight.
REQ-034 The block SHALL drive at most one bus strobe and at most one rsp_valid bit per cycle.

Reset
REQ-035 While rst = 0 at a clock edge:
- The FSM SHALL go to IDLE.
- rr_ptr, grant_id, the lock flag, the counter, addr, write_data and rsp_rdata SHALL become 0.
- wr_en, rd_en, req_ready, rsp_valid and busy SHALL be 0.
REQ-036 A reset during ISSUE or WAIT_RD SHALL abort the transaction with no rsp_valid; a strobe already issued SHALL not be repeated after reset.

Verification
REQ-037 Fixed priority: arb_mode=0, masters 0 and 1 both write at once (addr 0x10/0x20) -> master 0 is accepted first, wr_en with addr 0x10, then master 1 with 0x20; rsp_valid[0] before rsp_valid[1].
REQ-038 Round robin: arb_mode=1, NUM_MASTERS=4, all four continuously valid -> grants in order 0,1,2,3,0; each master is granted once per four transactions.
REQ-039 Read latency: RD_LAT=3, master 1 reads 0x3FFF, bus returns 0xBEEF -> rd_en 1 cycle after accept; rsp_valid[1] with rsp_rdata=0xBEEF 5 cycles after accept.
REQ-040 Lock: master 1 issues 3 writes with req_lock=1 while master 0 is valid in fixed mode -> all three of master 1's writes are granted before master 0; master 0 is granted once master 1 drops lock.
REQ-041 Reset mid-read: rst low during WAIT_RD -> busy=0 and rsp_valid=0 the next cycle; a subsequent request completes normally.
REQ-042 Back-to-back: single master with 10 consecutive writes -> exactly 10 wr_en pulses, the 10 corresponding addresses in order, one accept every 2 cycles.
